// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled instruction fetcher with prefetch queue, credit flow control and redirect flush
module fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INST_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [ADDR_W-1:0]         imem_addr,
    input  logic                      imem_gnt,
    input  logic                      imem_rvalid,
    input  logic [INST_W-1:0]         imem_rdata,
    input  logic                      redirect,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      out_valid,
    output logic [INST_W-1:0]         out_inst,
    output logic [ADDR_W-1:0]         out_pc,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));
    localparam logic [CW:0]       CREDITS    = (CW + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] q_inst [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [ADDR_W-1:0] tag_pc [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr, tag_rd, tag_wr;
    logic [CW-1:0]     count, inflight, kill;
    logic [CW:0]       credit_used;
    logic              issue, enq, deq;

    // Credits cover both queued words and words still owed by memory, so the queue cannot overflow.
    assign credit_used = {1'b0, count} + {1'b0, inflight};
    assign imem_req    = !rst && !redirect && (credit_used < CREDITS);
    assign imem_addr   = pc;
    assign issue       = imem_req && imem_gnt;

    assign enq         = !rst && imem_rvalid && !redirect && (kill == '0);
    assign out_valid   = !rst && !redirect && (count != '0);
    assign deq         = out_valid && out_ready;

    assign out_inst    = q_inst[rd_ptr];
    assign out_pc      = q_pc[rd_ptr];
    assign fifo_count  = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            kill     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
        end else begin
            // The tag FIFO tracks every outstanding transaction, killed or not.
            if (issue)
                tag_wr <= tag_wr + PW'(1);
            if (imem_rvalid)
                tag_rd <= tag_rd + PW'(1);
            inflight <= inflight + CW'(issue) - CW'(imem_rvalid);

            if (redirect) begin
                pc     <= redirect_pc & ALIGN_MASK;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                kill   <= inflight - CW'(imem_rvalid);
            end else begin
                if (issue)
                    pc <= pc + STEP;
                if (enq)
                    wr_ptr <= wr_ptr + PW'(1);
                if (deq)
                    rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(enq) - CW'(deq);
                if (imem_rvalid && (kill != '0))
                    kill <= kill - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue)
            tag_pc[tag_wr] <= pc;
        if (enq) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= tag_pc[tag_rd];
        end
    end

endmodule
